// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: decode-stage issue register that stalls on in-flight writers via a per-register pending scoreboard
module id_hazard_scoreboard #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int MAX_PEND = 3,
   parameter int MAX_INFLIGHT = 4,
   parameter bit ZERO_REG = 1,
   parameter bit WB_BYPASS = 1,
   localparam int NUM_REGS = 2**REG_AW,
   localparam int PW = $clog2(MAX_PEND+1),
   localparam int IW = $clog2(MAX_INFLIGHT+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_rs_used,
   input  logic              in_rt_used,
   input  logic              in_rd_write,
   input  logic [DATA_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic [REG_AW-1:0] out_rs,
   output logic [REG_AW-1:0] out_rt,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_rd_write,
   output logic [DATA_W-1:0] out_pc,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              flush,
   output logic              hazard,
   output logic [IW-1:0]     inflight,
   output logic [15:0]       stall_cycles
);
   logic [PW-1:0] pending [NUM_REGS];
   logic [PW-1:0] pend_nx [NUM_REGS];
   logic rs_pend, rt_pend, accept, inc, wb_hit, fl_raw, fl_hit;
   function automatic logic trk(input logic [REG_AW-1:0] a);
      return !ZERO_REG || a != '0;
   endfunction
   // a writeback retiring the last pending write clears the hazard in the same cycle
   assign rs_pend = pending[in_rs] != '0 && !(WB_BYPASS && wb_valid && wb_rd == in_rs && pending[in_rs] == PW'(1));
   assign rt_pend = pending[in_rt] != '0 && !(WB_BYPASS && wb_valid && wb_rd == in_rt && pending[in_rt] == PW'(1));
   assign hazard = in_valid && ((in_rs_used && rs_pend) || (in_rt_used && rt_pend) ||
                   (in_rd_write && trk(in_rd) && (pending[in_rd] == PW'(MAX_PEND) || inflight == IW'(MAX_INFLIGHT))));
   assign in_ready = !hazard && !flush && (!out_valid || out_ready);
   assign accept = in_valid && in_ready;
   assign inc = accept && in_rd_write && trk(in_rd);
   assign wb_hit = wb_valid && trk(wb_rd) && pending[wb_rd] != '0;
   assign fl_raw = flush && out_valid && out_rd_write && trk(out_rd);
   // the flush decrement only applies if the counter is still non-zero after any same-cycle writeback
   assign fl_hit = fl_raw && pending[out_rd] > PW'(wb_hit && wb_rd == out_rd);
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++)
         pend_nx[i] = pending[i] + PW'(inc && in_rd == REG_AW'(i)) - PW'(wb_hit && wb_rd == REG_AW'(i))
                      - PW'(fl_hit && out_rd == REG_AW'(i));
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) pending[i] <= '0;
         inflight <= '0;
         stall_cycles <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) pending[i] <= pend_nx[i];
         inflight <= inflight + IW'(inc) - IW'(wb_hit) - IW'(fl_hit);
         stall_cycles <= stall_cycles + 16'(hazard && stall_cycles != 16'hFFFF);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_opcode <= '0;
         out_rs <= '0;
         out_rt <= '0;
         out_rd <= '0;
         out_rd_write <= 1'b0;
         out_pc <= '0;
      end else begin
         out_valid <= accept || (out_valid && !out_ready && !flush);
         if (accept) begin
            out_opcode <= in_opcode;
            out_rs <= in_rs;
            out_rt <= in_rt;
            out_rd <= in_rd;
            out_rd_write <= in_rd_write;
            out_pc <= in_pc;
         end
      end
   end
endmodule
